// File: rtl/wrr_packet_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package wrr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    BETWEEN
  } arb_state_e;

  // Widest packed weight vector the slice helper accepts.
  localparam int unsigned MAX_WVEC_W = 1024;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] weight_slice(input logic [MAX_WVEC_W-1:0] vec,
                                               input int unsigned idx,
                                               input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(vec >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/wrr_packet_arbiter_if.sv
// FIFO-side / output-queue-side bundle of the weighted round-robin packet arbiter.
interface wrr_packet_arbiter_if #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned WEIGHT_W   = 4
);
  localparam int unsigned PTR_W = wrr_arb_pkg::ptr_width(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]          fifo_empty;
  logic [NUM_INPUTS-1:0]          fifo_last;
  logic [NUM_INPUTS*WEIGHT_W-1:0] weight;
  logic                           outq_ready;
  logic [NUM_INPUTS-1:0]          fifo_rd_en;
  logic                           grant_valid;
  logic [PTR_W-1:0]               grant_idx;
  logic                           grant_last;
  logic                           busy;

  modport master (
    output fifo_empty, fifo_last, weight, outq_ready,
    input  fifo_rd_en, grant_valid, grant_idx, grant_last, busy
  );

  modport slave (
    input  fifo_empty, fifo_last, weight, outq_ready,
    output fifo_rd_en, grant_valid, grant_idx, grant_last, busy
  );

endinterface

// File: rtl/wrr_packet_arbiter_rr_search.sv
// Combinational round-robin finder: first asserted request after base, wrapping mod NUM_INPUTS.
module rr_search #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned PTR_W      = 3
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [PTR_W-1:0]      base_i,
  output logic                  found_o,
  output logic [PTR_W-1:0]      idx_o
);

  always_comb begin : search
    int unsigned cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      cand = (32'(base_i) + k) % NUM_INPUTS;
      if (!found_o && req_i[PTR_W'(cand)]) begin
        found_o = 1'b1;
        idx_o   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter: N ingress FIFOs into one output queue,
// packet-atomic turns of up to weight[i] packets, pops issued in the same cycle.
module wrr_packet_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned WEIGHT_W   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  wrr_packet_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = ptr_width(NUM_INPUTS);

  logic [WEIGHT_W-1:0]   w_arr [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] eligible;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [PTR_W-1:0]    search_base;
  logic [PTR_W-1:0]    hit_idx;
  logic                hit;

  logic                start;
  logic [PTR_W-1:0]    start_idx;
  logic                cont;
  logic                pop;
  logic [PTR_W-1:0]    pop_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      w_arr[PTR_W'(i)]    = WEIGHT_W'(weight_slice(MAX_WVEC_W'(bus.weight), i, WEIGHT_W));
      eligible[PTR_W'(i)] = !bus.fifo_empty[PTR_W'(i)] && (w_arr[PTR_W'(i)] != '0);
    end
  end

  // One finder serves both the IDLE search and the BETWEEN release, which searches from owner.
  assign search_base = (state_q == BETWEEN) ? owner_q : rr_ptr_q;

  rr_search #(
    .NUM_INPUTS (NUM_INPUTS),
    .PTR_W      (PTR_W)
  ) u_rr_search (
    .req_i   (eligible),
    .base_i  (search_base),
    .found_o (hit),
    .idx_o   (hit_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    credit_d  = credit_q;
    start     = 1'b0;
    start_idx = '0;
    cont      = 1'b0;
    pop       = 1'b0;
    pop_idx   = '0;

    if (rst_n && bus.outq_ready) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            start     = 1'b1;
            start_idx = hit_idx;
          end
        end
        IN_PKT: begin
          if (!bus.fifo_empty[owner_q]) cont = 1'b1;
        end
        BETWEEN: begin
          if (eligible[owner_q]) begin
            cont = 1'b1;
          end else begin
            // Turn ends early: hand over in this same cycle rather than idling one.
            rr_ptr_d = owner_q;
            state_d  = IDLE;
            if (hit) begin
              start     = 1'b1;
              start_idx = hit_idx;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      pop     = 1'b1;
      pop_idx = start_idx;
      owner_d = start_idx;
      if (bus.fifo_last[start_idx]) begin
        if (w_arr[start_idx] == WEIGHT_W'(1)) begin
          rr_ptr_d = start_idx;
          state_d  = IDLE;
        end else begin
          credit_d = w_arr[start_idx] - WEIGHT_W'(1);
          state_d  = BETWEEN;
        end
      end else begin
        credit_d = w_arr[start_idx];
        state_d  = IN_PKT;
      end
    end else if (cont) begin
      pop     = 1'b1;
      pop_idx = owner_q;
      if (bus.fifo_last[owner_q]) begin
        if (credit_q == WEIGHT_W'(1)) begin
          rr_ptr_d = owner_q;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - WEIGHT_W'(1);
          state_d  = BETWEEN;
        end
      end else begin
        state_d = IN_PKT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NUM_INPUTS - 1);
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  always_comb begin
    bus.fifo_rd_en = '0;
    if (pop) bus.fifo_rd_en[pop_idx] = 1'b1;
    bus.grant_valid = pop;
    bus.grant_idx   = pop ? pop_idx : '0;
    bus.grant_last  = pop && bus.fifo_last[pop_idx];
  end

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed bench for wrr_packet_arbiter: behavioural FIFOs driven from per-input last-flag shift registers.
module tb_wrr_packet_arbiter;

  localparam int unsigned N = 5;
  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;

  wrr_packet_arbiter_if #(.NUM_INPUTS(N), .WEIGHT_W(W)) bus ();

  wrr_packet_arbiter #(
    .NUM_INPUTS (N),
    .WEIGHT_W   (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] lastbits [N];
  int unsigned cnt      [N];
  logic [N-1:0] hide;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.fifo_empty[3'(i)] = hide[3'(i)] || (cnt[3'(i)] == 0);
      bus.fifo_last[3'(i)]  = (cnt[3'(i)] != 0) ? lastbits[3'(i)][0] : 1'b0;
    end
  endtask

  task automatic push_pkt(input int i, input int len);
    for (int b = 0; b < len; b++) begin
      lastbits[3'(i)][5'(cnt[3'(i)])] = (b == len - 1);
      cnt[3'(i)]++;
    end
  endtask

  task automatic set_w(input int i, input logic [W-1:0] v);
    bus.weight = (bus.weight & ~(20'hF << (i * W))) | (20'(v) << (i * W));
  endtask

  task automatic reset_begin();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[3'(i)]      = 0;
      lastbits[3'(i)] = '0;
    end
    hide           = '0;
    bus.weight     = '0;
    bus.outq_ready = 1'b1;
    drive_inputs();
  endtask

  task automatic reset_end();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // e_idx < 0 means no beat may transfer this cycle.
  task automatic expect_cycle(input string tag, input int e_idx, input bit e_last, input bit e_busy);
    logic [N-1:0] rd;
    @(negedge clk);
    rd = bus.fifo_rd_en;
    if (e_idx < 0) begin
      chk($sformatf("%s.valid", tag), 32'(bus.grant_valid), 32'd0);
      chk($sformatf("%s.rd_en", tag), 32'(rd), 32'd0);
      chk($sformatf("%s.idx", tag), 32'(bus.grant_idx), 32'd0);
      chk($sformatf("%s.last", tag), 32'(bus.grant_last), 32'd0);
    end else begin
      chk($sformatf("%s.valid", tag), 32'(bus.grant_valid), 32'd1);
      chk($sformatf("%s.rd_en", tag), 32'(rd), 32'd1 << e_idx);
      chk($sformatf("%s.idx", tag), 32'(bus.grant_idx), 32'(e_idx));
      chk($sformatf("%s.last", tag), 32'(bus.grant_last), 32'(e_last));
    end
    chk($sformatf("%s.busy", tag), 32'(bus.busy), 32'(e_busy));
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rd[3'(i)] && cnt[3'(i)] > 0) begin
        lastbits[3'(i)] = lastbits[3'(i)] >> 1;
        cnt[3'(i)]--;
      end
    end
    #1 drive_inputs();
  endtask

  initial begin
    // Reset holds every output low even with eligible, ready traffic present.
    reset_begin();
    for (int i = 0; i < N; i++) begin
      set_w(i, 4'd1);
      push_pkt(i, 1);
      push_pkt(i, 1);
      push_pkt(i, 1);
    end
    drive_inputs();
    expect_cycle("rst", -1, 1'b0, 1'b0);

    // Equal weights, single-beat packets: plain rotation from input 0.
    reset_end();
    for (int k = 0; k < 10; k++) expect_cycle($sformatf("eq%0d", k), k % 5, 1'b1, 1'b0);

    // Weighted turns: 3 packets for input 0, 1 for input 1, zero-weight inputs skipped.
    reset_begin();
    set_w(0, 4'd3);
    set_w(1, 4'd1);
    for (int p = 0; p < 7; p++) push_pkt(0, 1);
    for (int p = 0; p < 3; p++) push_pkt(1, 1);
    for (int i = 2; i < N; i++) begin
      push_pkt(i, 1);
      push_pkt(i, 1);
    end
    drive_inputs();
    reset_end();
    for (int r = 0; r < 2; r++) begin
      expect_cycle($sformatf("wt%0d.a", r), 0, 1'b1, 1'b0);
      expect_cycle($sformatf("wt%0d.b", r), 0, 1'b1, 1'b1);
      expect_cycle($sformatf("wt%0d.c", r), 0, 1'b1, 1'b1);
      expect_cycle($sformatf("wt%0d.d", r), 1, 1'b1, 1'b0);
    end

    // Packet lock: owner runs dry mid-packet, eligible input 3 must wait.
    reset_begin();
    set_w(2, 4'd1);
    set_w(3, 4'd1);
    push_pkt(2, 4);
    push_pkt(3, 1);
    drive_inputs();
    reset_end();
    expect_cycle("lock.b1", 2, 1'b0, 1'b0);
    expect_cycle("lock.b2", 2, 1'b0, 1'b1);
    hide[2] = 1'b1;
    drive_inputs();
    for (int k = 0; k < 3; k++) expect_cycle($sformatf("lock.gap%0d", k), -1, 1'b0, 1'b1);
    hide[2] = 1'b0;
    drive_inputs();
    expect_cycle("lock.b3", 2, 1'b0, 1'b1);
    expect_cycle("lock.b4", 2, 1'b1, 1'b1);
    expect_cycle("lock.in3", 3, 1'b1, 1'b0);
    expect_cycle("lock.done", -1, 1'b0, 1'b0);

    // Backpressure freezes state and credit; input 0 still gets exactly two packets.
    reset_begin();
    set_w(0, 4'd2);
    set_w(1, 4'd1);
    push_pkt(0, 3);
    push_pkt(0, 1);
    push_pkt(1, 1);
    drive_inputs();
    reset_end();
    expect_cycle("bp.b1", 0, 1'b0, 1'b0);
    bus.outq_ready = 1'b0;
    expect_cycle("bp.s1", -1, 1'b0, 1'b1);
    bus.outq_ready = 1'b1;
    expect_cycle("bp.b2", 0, 1'b0, 1'b1);
    bus.outq_ready = 1'b0;
    expect_cycle("bp.s2", -1, 1'b0, 1'b1);
    bus.outq_ready = 1'b1;
    expect_cycle("bp.b3", 0, 1'b1, 1'b1);
    bus.outq_ready = 1'b0;
    expect_cycle("bp.s3", -1, 1'b0, 1'b1);
    bus.outq_ready = 1'b1;
    expect_cycle("bp.p2", 0, 1'b1, 1'b1);
    expect_cycle("bp.in1", 1, 1'b1, 1'b0);
    expect_cycle("bp.done", -1, 1'b0, 1'b0);

    // Early release: owner empties with credit left, input 4 granted next cycle.
    reset_begin();
    set_w(1, 4'd4);
    set_w(4, 4'd1);
    push_pkt(1, 2);
    push_pkt(4, 1);
    drive_inputs();
    reset_end();
    expect_cycle("rel.b1", 1, 1'b0, 1'b0);
    expect_cycle("rel.b2", 1, 1'b1, 1'b1);
    expect_cycle("rel.in4", 4, 1'b1, 1'b1);
    expect_cycle("rel.idle", -1, 1'b0, 1'b0);

    // Asynchronous reset inside a packet drops the lock immediately.
    reset_begin();
    for (int i = 0; i < N; i++) set_w(i, 4'd1);
    push_pkt(3, 4);
    drive_inputs();
    reset_end();
    expect_cycle("ar.b1", 3, 1'b0, 1'b0);
    expect_cycle("ar.b2", 3, 1'b0, 1'b1);
    push_pkt(1, 1);
    drive_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("ar.rst.valid", 32'(bus.grant_valid), 32'd0);
    chk("ar.rst.rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("ar.rst.idx", 32'(bus.grant_idx), 32'd0);
    chk("ar.rst.last", 32'(bus.grant_last), 32'd0);
    chk("ar.rst.busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_cycle("ar.in1", 1, 1'b1, 1'b0);
    expect_cycle("ar.b3", 3, 1'b0, 1'b0);
    expect_cycle("ar.b4", 3, 1'b1, 1'b1);
    expect_cycle("ar.done", -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wrr_packet_arbiter.md
Name: wrr_packet_arbiter

Overview:
- Next-generation output arbiter: N input FIFOs share one output queue.
- Adds per-input weights (packets per turn), packet atomicity via a head-of-FIFO last flag, runtime input masking (weight 0), and a visible grant index.
- Sits between the per-source ingress FIFOs and the single output queue.
- Drives FIFO read enables in the same cycle, so zero added latency to the data path.

Parameters:
- NUM_INPUTS, 5, number of requesting FIFOs (>=1).
- WEIGHT_W, 4, width of each per-input weight; max packets per turn = 2^WEIGHT_W-1.
- PTR_W, max(1,$clog2(NUM_INPUTS)), derived index width; not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_empty  in  NUM_INPUTS  per-input empty flag.
- fifo_last  in  NUM_INPUTS  head word of FIFO i is the final beat of its packet; valid only when !fifo_empty[i].
- weight  in  NUM_INPUTS*WEIGHT_W  packed weights, input i at [i*WEIGHT_W +: WEIGHT_W]; 0 = input disabled.
- outq_ready  in  1  output queue accepts a beat this cycle.
- fifo_rd_en  out  NUM_INPUTS  one-hot pop; a beat transfers when asserted.
- grant_valid  out  1  a beat transfers this cycle (= |fifo_rd_en).
- grant_idx  out  PTR_W  index of the popped FIFO; 0 when !grant_valid.
- grant_last  out  1  the popped beat carries last.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - Asynchronous assert; sync deassert handled upstream.
  - State=IDLE, rr_ptr=NUM_INPUTS-1 (input 0 searched first), owner=0, credit=0.
  - While rst_n=0, all outputs are 0.
- Eligibility: input i is eligible when !fifo_empty[i] && weight[i]!=0.
- RR search: scan (base+1..base+NUM_INPUTS) mod NUM_INPUTS and pick the first eligible input. Base=rr_ptr in IDLE, base=owner in BETWEEN.
- No output activity without outq_ready: fifo_rd_en=0 and no state change.
- FSM states IDLE, IN_PKT, BETWEEN:
  - IDLE, search hit idx, outq_ready=1:
    - Pop idx; owner<=idx.
    - Load credit from weight[idx], sampled only here.
    - Last=1 and weight=1: rr_ptr<=idx, stay IDLE.
    - Last=1 and weight>1: credit<=weight-1, go BETWEEN.
    - Last=0: credit<=weight, go IN_PKT.
  - IN_PKT (packet locked to owner):
    - Pop owner only when !fifo_empty[owner] && outq_ready.
    - Owner empty means stall; no other input is granted, even if eligible.
    - On popped last with credit==1: rr_ptr<=owner, go IDLE.
    - On popped last with credit>1: credit-1, go BETWEEN.
    - Weight changes and weight=0 on the owner do not abort the packet.
  - BETWEEN (owner holds the turn between packets):
    - Owner eligible and outq_ready: behave as IN_PKT start. Last=1 handled as in IN_PKT; last=0 goes to IN_PKT with credit unchanged.
    - Owner not eligible: release in the same cycle. rr_ptr<=owner, run the IDLE search from base owner, and take the IDLE transitions on a hit; with no hit, go IDLE.
- Credit decrements only on last beats, is never below 1 in IN_PKT/BETWEEN, and uses unsigned arithmetic of WEIGHT_W bits.
- Wrap-around: all index math mod NUM_INPUTS. NUM_INPUTS=1 degenerates to a packet-locked pass-through.
- fifo_last is ignored when fifo_empty=1.
- Reset mid-packet drops the lock immediately; no partial-packet recovery is done here.

Decomposition:
- Package wrr_arb_pkg: state enum arb_state_e {IDLE, IN_PKT, BETWEEN}; function for weight slice extraction.
- Sub-module rr_search (NUM_INPUTS, PTR_W): combinational first-eligible-after-base finder returning found and idx. Reused for the IDLE and BETWEEN-release paths.

Test Plan:
- Equal weights: weights all 1, all inputs non-empty, 1-beat packets, outq_ready=1 -> grant_idx sequence 0,1,2,3,4,0…; each fifo_rd_en one-hot.
- Weighted turns: weight0=3, weight1=1, others 0, both inputs hold 1-beat packets -> grants 0,0,0,1,0,0,0,1; inputs 2..4 never granted.
- Packet lock: input 2 has a 4-beat packet, input 3 non-empty, input 2 goes empty after beat 2 for 3 cycles -> no grants during the gap, beats 3-4 from input 2, then input 3.
- Backpressure: outq_ready toggles 1,0,1,0 mid-packet -> fifo_rd_en=0 and state/credit frozen in the 0 cycles; beat order intact.
- Early release: weight1=4, input 1 sends one packet then empties, input 4 non-empty -> input 4 is granted the cycle after the last beat, and busy drops to 0 via the same-cycle BETWEEN release.
- Async reset mid-packet: assert rst_n=0 between clock edges during IN_PKT -> outputs 0 immediately; after release, the first grant goes to the lowest eligible index starting from 0.
